shift_add_mult_ctrl: RTL and testbench

Sequential shift-and-add unsigned multiplier controller for the parallel-multiplier family. It owns a single WIDTH-bit add/shift stage plus product and operand registers, and sequences that stage over WIDTH iterations. It implements the same partial-product recurrence as the combinational array (add the multiplicand to the upper partial product when the multiplier bit is set, then shift right one), reusing one stage instead of WIDTH. It sits between a requester using a Start/Done handshake and any consumer of the 2·WIDTH-bit Product.

---
 rtl/shift_add_mult_ctrl_if.sv | 22 ++
 rtl/shift_add_mult_ctrl.sv | 91 +++++++++
 tb/tb_shift_add_mult_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_mult_ctrl_if.sv
// Start/Done request bus of the sequential shift-and-add multiplier.
// The requester uses the master modport and the multiplier uses the slave modport.
interface shift_add_mult_ctrl_if #(
  parameter int WIDTH = 4
);
  logic                 i_start;
  logic [WIDTH-1:0]     i_a;
  logic [WIDTH-1:0]     i_b;
  logic                 o_busy;
  logic                 o_done;
  logic [2*WIDTH-1:0]   o_product;

  modport master (
    output i_start, i_a, i_b,
    input  o_busy, o_done, o_product
  );

  modport slave (
    input  i_start, i_a, i_b,
    output o_busy, o_done, o_product
  );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier.
// One WIDTH-bit adder stage is reused over WIDTH iterations. Each iteration
// adds the multiplicand into the upper half of the partial product when the
// current multiplier bit is set, then shifts {Phi,Plo} right by one with the
// adder carry entering the MSB. The result is WIDTH+2 cycles per request:
// one accept edge, WIDTH iterations, and one DONE cycle.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  shift_add_mult_ctrl_if.slave  io_bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_areg;
  logic [WIDTH-1:0]     r_phi;
  logic [WIDTH-1:0]     r_plo;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_busy;
  logic                 r_done;

  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_shifted;

  // The single add stage: carry is kept so the shift never loses a bit.
  assign w_sum     = {1'b0, r_phi} + (r_plo[0] ? {1'b0, r_areg} : '0);
  assign w_shifted = {w_sum, r_plo[WIDTH-1:1]};

  // Controller and datapath: accept, iterate WIDTH times, pulse done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_areg    <= '0;
      r_phi     <= '0;
      r_plo     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.i_start) begin
            r_areg  <= io_bus.i_a;
            r_phi   <= '0;
            r_plo   <= io_bus.i_b;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          {r_phi, r_plo} <= w_shifted;
          r_cnt          <= r_cnt + CW'(1);
          // Last iteration: the shifted value is the finished product.
          if (r_cnt == LAST_ITER) begin
            r_product <= w_shifted;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.o_busy    = r_busy;
  assign io_bus.o_done    = r_done;
  assign io_bus.o_product = r_product;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl (WIDTH=4 main instance, WIDTH=8 spot check).
module tb_shift_add_mult_ctrl;

  localparam int W4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   cmp_en = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  shift_add_mult_ctrl_if #(.WIDTH(4)) if4();
  shift_add_mult_ctrl_if #(.WIDTH(8)) if8();

  shift_add_mult_ctrl #(.WIDTH(4)) dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (if4.slave)
  );

  shift_add_mult_ctrl #(.WIDTH(8)) dut8 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (if8.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural timeline model: a request accepted on edge n0 is busy after
  // edges n0..n0+W-1, done after edge n0+W (product = a*b appears there), and
  // the unit can accept again from edge n0+W+2 on.
  bit m_active = 1'b0;
  int m_k      = 0;
  int m_pend   = 0;
  int exp_prod = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_pend   <= 0;
      exp_prod <= 0;
    end else if (m_active) begin
      m_k <= m_k + 1;
      if (m_k + 1 == W4) exp_prod <= m_pend;
      if (m_k == W4) m_active <= 1'b0;
    end else if (if4.i_start) begin
      m_active <= 1'b1;
      m_k      <= 0;
      m_pend   <= int'(if4.i_a) * int'(if4.i_b);
    end
  end

  // Per-cycle comparison of the WIDTH=4 instance against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy",    32'(if4.o_busy),    32'(m_active && (m_k < W4)));
      chk("done",    32'(if4.o_done),    32'(m_active && (m_k == W4)));
      chk("product", 32'(if4.o_product), 32'(exp_prod));
      $display("cyc busy=%0b done=%0b product=%0d", if4.o_busy, if4.o_done, if4.o_product);
    end
  end

  // One WIDTH=4 request with a hand-computed expected product.
  task automatic run_one(input int a, input int b, input int lit);
    int busy_n;
    int done_at;
    busy_n  = 0;
    done_at = 0;
    @(negedge clk);
    if4.i_a     = 4'(a);
    if4.i_b     = 4'(b);
    if4.i_start = 1'b1;
    for (int n = 1; n <= 20 && done_at == 0; n++) begin
      @(negedge clk);
      if (n == 1) if4.i_start = 1'b0;
      if (if4.o_busy) busy_n++;
      if (if4.o_done) done_at = n;
    end
    chk("busy_cycles", 32'(busy_n), 32'd4);
    chk("done_cycle", 32'(done_at), 32'd5);
    chk("product_lit", 32'(if4.o_product), 32'(lit));
    repeat (2) @(negedge clk);
    chk("product_hold", 32'(if4.o_product), 32'(lit));
    $display("txn w4 a=%0d b=%0d product=%0d done_cycle=%0d", a, b, if4.o_product, done_at);
  endtask

  // One WIDTH=8 request.
  task automatic run8(input int a, input int b, input int expv);
    int busy_n;
    int done_at;
    busy_n  = 0;
    done_at = 0;
    @(negedge clk);
    if8.i_a     = 8'(a);
    if8.i_b     = 8'(b);
    if8.i_start = 1'b1;
    for (int n = 1; n <= 30 && done_at == 0; n++) begin
      @(negedge clk);
      if (n == 1) if8.i_start = 1'b0;
      if (if8.o_busy) busy_n++;
      if (if8.o_done) done_at = n;
    end
    chk("w8_busy_cycles", 32'(busy_n), 32'd8);
    chk("w8_done_cycle", 32'(done_at), 32'd9);
    chk("w8_product", 32'(if8.o_product), 32'(expv));
    $display("txn w8 a=%0d b=%0d product=%0d done_cycle=%0d", a, b, if8.o_product, done_at);
  endtask

  initial begin
    int done_seen;
    if4.i_start = 1'b0; if4.i_a = '0; if4.i_b = '0;
    if8.i_start = 1'b0; if8.i_a = '0; if8.i_b = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_busy", 32'(if4.o_busy), 32'd0);
    chk("reset_done", 32'(if4.o_done), 32'd0);
    chk("reset_product", 32'(if4.o_product), 32'd0);
    #2 rst_n = 1'b1;

    // Largest operands.
    run_one(15, 15, 225);

    // 13*11 with Start pulses (A=B=1) during RUN/DONE that must be ignored.
    @(negedge clk);
    if4.i_a = 4'd13; if4.i_b = 4'd11; if4.i_start = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if4.i_a = 4'd1; if4.i_b = 4'd1;
      if4.i_start = (n == 2 || n == 4);
    end
    chk("m13x11_done", 32'(if4.o_done), 32'd1);
    chk("m13x11_product", 32'(if4.o_product), 32'd143);
    repeat (3) @(negedge clk);
    chk("m13x11_no_accept", 32'(if4.o_busy), 32'd0);
    chk("m13x11_hold", 32'(if4.o_product), 32'd143);
    $display("txn w4 a=13 b=11 product=%0d", if4.o_product);

    // Abandon 7*6 with reset during the second RUN cycle.
    @(negedge clk);
    if4.i_a = 4'd7; if4.i_b = 4'd6; if4.i_start = 1'b1;
    @(negedge clk);
    if4.i_start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_product", 32'(if4.o_product), 32'd0);
    chk("abort_busy", 32'(if4.o_busy), 32'd0);
    chk("abort_done", 32'(if4.o_done), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    done_seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (if4.o_done) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    $display("txn w4 abort a=7 b=6 product=%0d", if4.o_product);
    run_one(7, 6, 42);

    // Zero operands.
    run_one(0, 9, 0);
    run_one(9, 0, 0);

    // Back-to-back sweep of all 256 pairs with Start held high.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if4.i_a = 4'(i >> 4); if4.i_b = 4'(i); if4.i_start = 1'b1;
      chk("sweep_idle", 32'(if4.o_busy | if4.o_done), 32'd0);
      @(negedge clk);
      chk("sweep_accept", 32'(if4.o_busy), 32'd1);
      repeat (4) @(negedge clk);
      chk("sweep_product", 32'(if4.o_product), 32'((i >> 4) * (i & 15)));
      $display("txn sweep a=%0d b=%0d product=%0d", i >> 4, i & 15, if4.o_product);
    end
    if4.i_start = 1'b0;

    // Random start/operand traffic checked by the model every cycle.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if4.i_start = ($urandom_range(0, 2) == 0);
      if4.i_a     = 4'($urandom);
      if4.i_b     = 4'($urandom);
    end
    @(negedge clk);
    if4.i_start = 1'b0;
    repeat (8) @(negedge clk);

    // WIDTH=8 instance.
    run8(255, 255, 65025);
    for (int n = 0; n < 3; n++) begin
      int ra;
      int rb;
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      run8(ra, rb, ra * rb);
    end

    cmp_en = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
